// File: rtl/de_scoreboard_pkg.sv
// Shared definitions for the decode-stage register scoreboard: default
// register-file geometry and the small counting helper used by hazard logic.
package de_scoreboard_pkg;

  localparam int SB_NUM_REGS  = 32;
  localparam int SB_REGNOBITS = 5;

  typedef logic [SB_REGNOBITS-1:0] regno_t;

  // Number of set bits in a two-port release vector (at most two WB ports).
  function automatic logic [1:0] count2(input logic [1:0] v);
    return {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

endpackage

// File: rtl/de_scoreboard_if.sv
// Issue / write-back / flush bundle between DE control and the scoreboard.
interface de_scoreboard_if #(
  parameter int NUM_REGS  = 32,
  parameter int REGNOBITS = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 1
);
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC*REGNOBITS-1:0] src_regno;
  logic                         dst_valid;
  logic [REGNOBITS-1:0]         dst_regno;
  logic                         issue_req;
  logic                         issue_fire;
  logic                         stall;
  logic [NUM_WB-1:0]            wb_valid;
  logic [NUM_WB*REGNOBITS-1:0]  wb_regno;
  logic                         flush;
  logic [NUM_REGS-1:0]          busy_vec;
  logic                         err_underflow;

  modport master (
    output src_valid, src_regno, dst_valid, dst_regno, issue_req,
           wb_valid, wb_regno, flush,
    input  issue_fire, stall, busy_vec, err_underflow
  );

  modport slave (
    input  src_valid, src_regno, dst_valid, dst_regno, issue_req,
           wb_valid, wb_regno, flush,
    output issue_fire, stall, busy_vec, err_underflow
  );
endinterface

// File: rtl/de_scoreboard_sb_counter.sv
// In-flight writer counter for one architectural register; excess releases
// are dropped and reported through a same-cycle underflow pulse.
module sb_counter
  import de_scoreboard_pkg::*;
#(
  parameter int CNT_BITS = 2,
  parameter int NUM_WB   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                inc,
  input  logic [NUM_WB-1:0]   dec,
  output logic [CNT_BITS-1:0] cnt,
  output logic                busy,
  output logic                underflow
);

  localparam int AW = CNT_BITS + 2;

  logic [AW-1:0]       avail_s;
  logic [AW-1:0]       req_s;
  logic [AW-1:0]       take_s;
  logic [AW-1:0]       next_s;
  logic                uflow_s;
  logic [CNT_BITS-1:0] cnt_r;
  logic                busy_r;

  // Next count: releases are honoured only up to what is in flight after the issue.
  always_comb begin
    avail_s = AW'(cnt_r) + AW'(inc);
    req_s   = AW'(count2(2'(dec)));
    if (req_s > avail_s) begin
      take_s  = avail_s;
      uflow_s = 1'b1;
    end else begin
      take_s  = req_s;
      uflow_s = 1'b0;
    end
    next_s = avail_s - take_s;
  end

  // Counter and busy flag; flush clears without regard to this cycle's traffic.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (clear) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= next_s[CNT_BITS-1:0];
      busy_r <= (next_s != '0);
    end
  end

  assign cnt       = cnt_r;
  assign busy      = busy_r;
  assign underflow = uflow_s;

endmodule

// File: rtl/de_scoreboard.sv
// Decode-stage register scoreboard: per-register writer counters, source and
// destination hazard detection, FE stall and DE latch issue strobe.
module de_scoreboard
  import de_scoreboard_pkg::*;
#(
  parameter int NUM_REGS  = SB_NUM_REGS,
  parameter int REGNOBITS = SB_REGNOBITS,
  parameter int NUM_SRC   = 2,
  parameter int NUM_WB    = 1,
  parameter int CNT_BITS  = 2,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk,
  input  logic            reset,
  de_scoreboard_if.slave  sb
);

  localparam int CW = CNT_BITS + 2;

  logic [CNT_BITS-1:0]  cnt_s     [NUM_REGS];
  logic [NUM_WB-1:0]    wb_hit_s  [NUM_REGS];
  logic [REGNOBITS-1:0] src_rn_s  [NUM_SRC];
  logic [NUM_REGS-1:0]  busy_s;
  logic [NUM_REGS-1:1]  inc_s;
  logic [NUM_REGS-1:1]  uflow_s;
  logic                 src_haz_s;
  logic                 dst_haz_s;
  logic                 stall_s;
  logic                 fire_s;
  logic                 err_r;

  // Which WB ports release each register this cycle (register 0 never matches).
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int w = 0; w < NUM_WB; w++) begin
        wb_hit_s[r][w] = sb.wb_valid[w] && (r != 0) &&
                         (sb.wb_regno[w*REGNOBITS +: REGNOBITS] == REGNOBITS'(r));
      end
    end
  end

  // Source hazards, optionally crediting same-cycle releases.
  always_comb begin
    src_haz_s = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_rn_s[k] = sb.src_regno[k*REGNOBITS +: REGNOBITS];
      if (sb.src_valid[k] && (src_rn_s[k] != '0)) begin
        if (WB_BYPASS != 0) begin
          src_haz_s = src_haz_s ||
                      (CW'(cnt_s[src_rn_s[k]]) > CW'(count2(2'(wb_hit_s[src_rn_s[k]]))));
        end else begin
          src_haz_s = src_haz_s || (cnt_s[src_rn_s[k]] != '0);
        end
      end else begin
        src_haz_s = src_haz_s;
      end
    end
  end

  // A saturated destination counter blocks issue; releases give no credit here.
  always_comb begin
    dst_haz_s = sb.dst_valid && (sb.dst_regno != '0) && (cnt_s[sb.dst_regno] == '1);
    stall_s   = sb.issue_req && (src_haz_s || dst_haz_s);
    fire_s    = sb.issue_req && !stall_s && !sb.flush;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_s[r] = fire_s && sb.dst_valid && (sb.dst_regno == REGNOBITS'(r));
    end
  end

  assign cnt_s[0]  = '0;
  assign busy_s[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(
      .CNT_BITS (CNT_BITS),
      .NUM_WB   (NUM_WB)
    ) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (sb.flush),
      .inc       (inc_s[r]),
      .dec       (wb_hit_s[r]),
      .cnt       (cnt_s[r]),
      .busy      (busy_s[r]),
      .underflow (uflow_s[r])
    );
  end

  // Sticky underflow flag; a flush cycle neither sets nor clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (sb.flush) begin
      err_r <= err_r;
    end else if (|uflow_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign sb.issue_fire    = fire_s;
  assign sb.stall         = stall_s;
  assign sb.busy_vec      = busy_s;
  assign sb.err_underflow = err_r;

endmodule

// File: tb/tb_de_scoreboard.sv
// Directed vector bench for de_scoreboard: bypass variant driven from a table,
// non-bypass variant exercised by a short hand-written sequence.
module tb_de_scoreboard;
  import de_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  de_scoreboard_if #(.NUM_REGS(32), .REGNOBITS(5), .NUM_SRC(2), .NUM_WB(2)) ifa ();
  de_scoreboard_if #(.NUM_REGS(32), .REGNOBITS(5), .NUM_SRC(2), .NUM_WB(2)) ifb ();

  de_scoreboard #(.NUM_REGS(32), .REGNOBITS(5), .NUM_SRC(2), .NUM_WB(2),
                  .CNT_BITS(2), .WB_BYPASS(1)) dut_a (.clk(clk), .reset(reset), .sb(ifa));
  de_scoreboard #(.NUM_REGS(32), .REGNOBITS(5), .NUM_SRC(2), .NUM_WB(2),
                  .CNT_BITS(2), .WB_BYPASS(0)) dut_b (.clk(clk), .reset(reset), .sb(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sv;
    logic [4:0]  s0, s1;
    logic        dv;
    logic [4:0]  d;
    logic        req;
    logic [1:0]  wv;
    logic [4:0]  w0, w1;
    logic        fl;
    logic        e_stall, e_fire;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] sv, logic [4:0] s0, logic [4:0] s1,
                              logic dv, logic [4:0] d, logic req,
                              logic [1:0] wv, logic [4:0] w0, logic [4:0] w1, logic fl,
                              logic e_stall, logic e_fire, logic [31:0] e_busy, logic e_err);
    vec_t v;
    v.sv = sv; v.s0 = s0; v.s1 = s1; v.dv = dv; v.d = d; v.req = req;
    v.wv = wv; v.w0 = w0; v.w1 = w1; v.fl = fl;
    v.e_stall = e_stall; v.e_fire = e_fire; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    ifa.src_valid = v.sv;
    ifa.src_regno = {v.s1, v.s0};
    ifa.dst_valid = v.dv;
    ifa.dst_regno = v.d;
    ifa.issue_req = v.req;
    ifa.wb_valid  = v.wv;
    ifa.wb_regno  = {v.w1, v.w0};
    ifa.flush     = v.fl;
  endtask

  task automatic drive_b(input logic [1:0] sv, input logic [4:0] s0, input logic dv,
                         input logic [4:0] d, input logic req, input logic [1:0] wv,
                         input logic [4:0] w0);
    ifb.src_valid = sv;
    ifb.src_regno = {5'd0, s0};
    ifb.dst_valid = dv;
    ifb.dst_regno = d;
    ifb.issue_req = req;
    ifb.wb_valid  = wv;
    ifb.wb_regno  = {5'd0, w0};
    ifb.flush     = 1'b0;
  endtask

  initial begin
    vec_t idle;
    n_cmp = 0;
    n_err = 0;

    //        sv    s0    s1    dv    d     req   wv    w0     w1     fl  | stall fire busy          err
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd5, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h20,  1'b0));
    tbl.push_back(mk(2'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h20,  1'b0));
    tbl.push_back(mk(2'd1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1, 5'd5,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,   1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h80,  1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 2'd1, 5'd7,  5'd0,  1'b0, 1'b1, 1'b0, 32'h80,  1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd7, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h80,  1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd3, 5'd7,  5'd7,  1'b0, 1'b0, 1'b0, 32'h80,  1'b0));
    tbl.push_back(mk(2'd3, 5'd7, 5'd0, 1'b0, 5'd0, 1'b1, 2'd1, 5'd7,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,   1'b0));
    tbl.push_back(mk(2'd3, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,   1'b0));
    tbl.push_back(mk(2'd3, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 2'd1, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h0,   1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h8,   1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h8,   1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 32'h208, 1'b0));
    tbl.push_back(mk(2'd2, 5'd0, 5'd9, 1'b0, 5'd0, 1'b1, 2'd0, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 32'h208, 1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd9, 1'b1, 2'd1, 5'd9,  5'd0,  1'b0, 1'b0, 1'b1, 32'h208, 1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 2'd1, 5'd3,  5'd0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b0));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd1, 5'd12, 5'd0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 32'h0,   1'b1));
    tbl.push_back(mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 32'h0,   1'b1));

    idle = mk(2'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    drive_a(idle);
    drive_b(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy_a", ifa.busy_vec, 32'h0);
    chk("reset_err_a", 32'(ifa.err_underflow), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive_a(tbl[i]);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(ifa.stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d_fire", i), 32'(ifa.issue_fire), 32'(tbl[i].e_fire));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), ifa.busy_vec, tbl[i].e_busy);
      chk($sformatf("v%0d_err", i), 32'(ifa.err_underflow), 32'(tbl[i].e_err));
    end

    // Sticky error clears only through reset.
    @(negedge clk);
    drive_a(idle);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_clears_err", 32'(ifa.err_underflow), 32'h0);
    chk("rst_busy", ifa.busy_vec, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Non-bypass variant: a same-cycle release is seen only on the next cycle.
    @(negedge clk);
    drive_b(2'd0, 5'd0, 1'b1, 5'd5, 1'b1, 2'd0, 5'd0);
    #1;
    chk("nb_issue_fire", 32'(ifb.issue_fire), 32'h1);
    @(posedge clk);
    #1;
    chk("nb_busy5", ifb.busy_vec, 32'h20);
    @(negedge clk);
    drive_b(2'd1, 5'd5, 1'b0, 5'd0, 1'b1, 2'd1, 5'd5);
    #1;
    chk("nb_wb_same_stall", 32'(ifb.stall), 32'h1);
    chk("nb_wb_same_fire", 32'(ifb.issue_fire), 32'h0);
    @(posedge clk);
    #1;
    chk("nb_busy_clear", ifb.busy_vec, 32'h0);
    @(negedge clk);
    drive_b(2'd1, 5'd5, 1'b0, 5'd0, 1'b1, 2'd0, 5'd0);
    #1;
    chk("nb_next_stall", 32'(ifb.stall), 32'h0);
    chk("nb_next_fire", 32'(ifb.issue_fire), 32'h1);
    @(negedge clk);
    drive_b(2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
